seg7_scan: RTL and testbench

- Consumer end of the divided-clock generator: takes the 100 Hz refresh square wave and the 5 Hz blink square wave as plain data inputs.
- Re-times both into the master_clk domain and time-multiplexes a 4-digit, active-low, common-anode 7-segment display.
- Per-digit blinking and hex decode are included; all logic runs on master_clk only.

---
 rtl/seg7_pkg.sv | 12 +
 rtl/seg7_scan_sync_edge.sv | 24 ++
 rtl/seg7_scan.sv | 49 ++++
 tb/tb_seg7_scan.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and active-low hex decode for the 4-digit scanned display
package seg7_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] decode(input logic [3:0] n);
    return SEG_TABLE[n];
  endfunction
endpackage

// File: rtl/seg7_scan_sync_edge.sv
// sync_edge: multi-flop synchronizer for a slow async input, plus a one-cycle rising-edge pulse
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);
  logic [STAGES-1:0] sr;
  logic prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      prev <= 1'b0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
      prev <= sr[STAGES-1];
    end
  end
  assign level = sr[STAGES-1];
  assign rise = level & ~prev;
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit active-low 7-segment multiplexer driven by re-timed 100 Hz / 5 Hz square waves
// Optional SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                    master_clk,
  input  logic                    rst,
  input  logic                    clk_100,
  input  logic                    clk_5,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);
  logic tick, blink_lvl, unused_lvl, unused_rise, blank, lz;
  logic [1:0] idx;
  logic [3:0] nib;
  sync_edge #(.STAGES(SYNC_STAGES)) u_refresh (
    .clk(master_clk), .rst(rst), .d(clk_100), .level(unused_lvl), .rise(tick)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_blink (
    .clk(master_clk), .rst(rst), .d(clk_5), .level(blink_lvl), .rise(unused_rise)
  );
  assign nib = digits[{idx, 2'b00} +: 4];
  assign blank = blink_mask[idx] & blink_lvl;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign lz = (idx != 2'd0) && ((digits >> {idx, 2'b00}) == '0);
`else
  assign lz = 1'b0;
`endif
  // an stays driven during blink so every digit gets the same duty cycle
  always_ff @(posedge master_clk) begin
    if (rst) begin
      an <= '1;
      seg <= SEG_BLANK;
      dp <= 1'b1;
      idx <= '0;
    end else if (tick) begin
      an <= ~(NUM_DIGITS'(1) << idx);
      seg <= (blank || lz) ? SEG_BLANK : decode(nib);
      dp <= blank | ~dp_in[idx];
      idx <= idx + 2'd1;
    end
  end
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard-driven self-checking bench for seg7_scan
module tb_seg7_scan;
  logic master_clk = 1'b0;
  logic rst = 1'b1;
  logic clk_100 = 1'b0;
  logic clk_5 = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0] dp_in = 4'h0;
  logic [3:0] blink_mask = 4'h0;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  int n_cmp = 0;
  int n_err = 0;
  int m_idx = 0;
  logic [11:0] sb[$];
  logic [11:0] exp_v, got;
  localparam logic [11:0] RST_V = {4'b1111, 7'h7F, 1'b1};
  logic [6:0] ref_seg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg7_scan dut (
    .master_clk(master_clk), .rst(rst), .clk_100(clk_100), .clk_5(clk_5),
    .digits(digits), .dp_in(dp_in), .blink_mask(blink_mask),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 master_clk = ~master_clk;

  function automatic logic [11:0] model();
    logic [3:0] nib;
    logic bl, lz;
    logic [3:0] a;
    logic [6:0] s;
    nib = 4'((digits >> (4 * m_idx)) & 16'hF);
    bl = blink_mask[m_idx] & clk_5;
    lz = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lz = (m_idx != 0) && ((digits >> (4 * m_idx)) == 16'h0);
`endif
    a = 4'b1111;
    a[m_idx] = 1'b0;
    s = (bl || lz) ? 7'h7F : ref_seg[nib];
    return {a, s, bl | ~dp_in[m_idx]};
  endfunction

  // one clk_100 rising edge; returns at the negedge after the edge where outputs update
  task automatic rise_100();
    @(negedge master_clk);
    clk_100 = 1'b1;
    sb.push_back(model());
    m_idx = (m_idx + 1) % 4;
    repeat (3) @(posedge master_clk);
    @(negedge master_clk);
    clk_100 = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge master_clk);
    rst = 1'b1;
    @(negedge master_clk);
    rst = 1'b0;
    m_idx = 0;
  endtask

  task automatic test_reset();
    @(posedge master_clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge master_clk);
      got = {an, seg, dp};
      n_cmp++;
      if (got !== RST_V) begin
        n_err++;
        $display("FAIL reset_hold[%0d] got=%h exp=%h", i, got, RST_V);
      end
      clk_100 = ~clk_100;
    end
    @(negedge master_clk);
    clk_100 = 1'b0;
    rst = 1'b0;
    m_idx = 0;
    digits = 16'h1234;
    repeat (3) @(negedge master_clk);
    rise_100();
    exp_v = sb.pop_front();
    got = {an, seg, dp};
    n_cmp++;
    if (got !== exp_v || an !== 4'b1110) begin
      n_err++;
      $display("FAIL reset_first_tick got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_scan();
    logic [3:0] an_exp [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [6:0] seg_exp [5] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h19};
    pulse_rst();
    digits = 16'h1234;
    dp_in = 4'h0;
    blink_mask = 4'h0;
    for (int i = 0; i < 5; i++) begin
      rise_100();
      exp_v = sb.pop_front();
      got = {an, seg, dp};
      n_cmp++;
      if (got !== exp_v || an !== an_exp[i] || seg !== seg_exp[i]) begin
        n_err++;
        $display("FAIL scan[%0d] got=%h exp=%h an_req=%b seg_req=%h", i, got, exp_v, an_exp[i], seg_exp[i]);
      end
    end
  endtask

  task automatic test_latency();
    logic [11:0] prev_v;
    int changes;
    @(negedge master_clk);
    prev_v = {an, seg, dp};
    clk_100 = 1'b1;
    sb.push_back(model());
    m_idx = (m_idx + 1) % 4;
    for (int e = 0; e < 2; e++) begin
      @(posedge master_clk);
      @(negedge master_clk);
      got = {an, seg, dp};
      n_cmp++;
      if (got !== prev_v) begin
        n_err++;
        $display("FAIL latency_early[k+%0d] got=%h exp=%h", e, got, prev_v);
      end
    end
    @(posedge master_clk);
    @(negedge master_clk);
    exp_v = sb.pop_front();
    got = {an, seg, dp};
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL latency_k+2 got=%h exp=%h", got, exp_v);
    end
    changes = 0;
    prev_v = got;
    repeat (1000) begin
      @(negedge master_clk);
      if ({an, seg, dp} !== prev_v) changes++;
      prev_v = {an, seg, dp};
    end
    n_cmp++;
    if (changes !== 0) begin
      n_err++;
      $display("FAIL latency_hold got=%0d changes exp=0", changes);
    end
    clk_100 = 1'b0;
  endtask

  task automatic test_blink();
    pulse_rst();
    digits = 16'h1234;
    blink_mask = 4'b0001;
    dp_in = 4'b0001;
    clk_5 = 1'b1;
    repeat (4) @(negedge master_clk);
    for (int i = 0; i < 4; i++) begin
      rise_100();
      exp_v = sb.pop_front();
      got = {an, seg, dp};
      n_cmp++;
      if (got !== exp_v || (i == 0 && got !== {4'b1110, 7'h7F, 1'b1})) begin
        n_err++;
        $display("FAIL blink_on[%0d] got=%h exp=%h", i, got, exp_v);
      end
    end
    clk_5 = 1'b0;
    repeat (4) @(negedge master_clk);
    rise_100();
    exp_v = sb.pop_front();
    got = {an, seg, dp};
    n_cmp++;
    if (got !== exp_v || got !== {4'b1110, 7'h19, 1'b0}) begin
      n_err++;
      $display("FAIL blink_off got=%h exp=%h", got, exp_v);
    end
    blink_mask = 4'h0;
    dp_in = 4'h0;
  endtask

  task automatic test_hex_reset();
    logic [6:0] seg_exp [2] = '{7'h46, 7'h21};
    pulse_rst();
    digits = 16'hFEDC;
    for (int i = 0; i < 2; i++) begin
      rise_100();
      exp_v = sb.pop_front();
      got = {an, seg, dp};
      n_cmp++;
      if (got !== exp_v || seg !== seg_exp[i]) begin
        n_err++;
        $display("FAIL hex[%0d] got=%h exp=%h", i, got, exp_v);
      end
    end
    pulse_rst();
    got = {an, seg, dp};
    n_cmp++;
    if (got !== RST_V) begin
      n_err++;
      $display("FAIL midscan_reset got=%h exp=%h", got, RST_V);
    end
    rise_100();
    exp_v = sb.pop_front();
    got = {an, seg, dp};
    n_cmp++;
    if (got !== exp_v || got !== {4'b1110, 7'h46, 1'b1}) begin
      n_err++;
      $display("FAIL after_reset_tick got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_leading_zero();
    pulse_rst();
    digits = 16'h0040;
    for (int i = 0; i < 4; i++) begin
      rise_100();
      exp_v = sb.pop_front();
      got = {an, seg, dp};
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL leading_zero[%0d] got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      digits = 16'($urandom);
      dp_in = 4'($urandom);
      blink_mask = 4'($urandom);
      clk_5 = 1'($urandom);
      repeat (4) @(negedge master_clk);
      rise_100();
      exp_v = sb.pop_front();
      got = {an, seg, dp};
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL random[%0d] got=%h exp=%h digits=%h dp_in=%b mask=%b c5=%b", i, got, exp_v, digits, dp_in, blink_mask, clk_5);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_latency();
    test_blink();
    test_hex_reset();
    test_leading_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
